// File: rtl/seven_segment_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_pkg
// Description : Segment patterns {a,b,c,d,e,f,g} and sizing helpers for the
//               multiplexed seven-segment scanner.
// Revision    : 1.0
// ============================================================================
package seven_segment_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_E_ERR = 7'b1001111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Width of a counter that spans 0..div-1.
    function automatic int presc_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_decode.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_decode
// Description : Combinational hex nibble to seven-segment pattern decoder.
// Revision    : 1.0
// ============================================================================
module seven_segment_decode
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scan.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scan
// Description : Time-multiplexed multi-digit seven-segment driver with
//               frame-synchronous value update. Optional leading-zero
//               blanking is enabled by SEVEN_SEG_LEADING_ZERO_BLANK_EN.
// Revision    : 1.0
// ============================================================================
module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  error,
    output logic                  seg_a,
    output logic                  seg_b,
    output logic                  seg_c,
    output logic                  seg_d,
    output logic                  seg_e,
    output logic                  seg_f,
    output logic                  seg_g,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int c_PW = presc_width(REFRESH_DIV);
    localparam int c_IW = $clog2(DIGITS);
    localparam logic [c_PW-1:0]   c_PRESC_LAST = c_PW'(REFRESH_DIV - 1);
    localparam logic [c_PW-1:0]   c_PRESC_ONE  = c_PW'(1);
    localparam logic [c_IW-1:0]   c_IDX_LAST   = c_IW'(DIGITS - 1);
    localparam logic [c_IW-1:0]   c_IDX_ONE    = c_IW'(1);
    localparam logic [DIGITS-1:0] c_AN_ONE     = DIGITS'(1);

    logic [c_PW-1:0]     r_presc;
    logic [c_IW-1:0]     r_idx;
    logic [4*DIGITS-1:0] r_shadow_val;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [4*DIGITS-1:0] r_disp_val;
    logic [DIGITS-1:0]   r_disp_dp;
    logic                r_pending;
    logic                r_wrap_d;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_wrap;
    logic [3:0]          w_nibble;
    logic [6:0]          w_dec_seg;
    logic [6:0]          w_seg_next;
    logic                w_dp_next;

    assign w_tick   = (r_presc == c_PRESC_LAST);
    assign w_wrap   = w_tick && (r_idx == c_IDX_LAST);
    assign w_nibble = r_disp_val[{r_idx, 2'b00} +: 4];

    seven_segment_decode u_decode (
        .nibble (w_nibble),
        .seg    (w_dec_seg)
    );

    always_comb begin
        w_seg_next = w_dec_seg;
        w_dp_next  = r_disp_dp[r_idx];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        // Blank when this and every higher nibble is zero; digit 0 always lit.
        if ((r_idx != '0) && ((r_disp_val >> {r_idx, 2'b00}) == '0)) begin
            w_seg_next = SEG_BLANK;
            w_dp_next  = 1'b0;
        end
`endif
        if (error) begin
            w_seg_next = SEG_E_ERR;
            w_dp_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_pending    <= 1'b0;
            r_wrap_d     <= 1'b0;
            r_seg        <= '0;
            r_dp         <= 1'b0;
            r_an         <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PRESC_ONE;
            if (w_tick) begin
                r_idx <= w_wrap ? '0 : r_idx + c_IDX_ONE;
            end

            // Display only changes at the frame wrap, so a frame never tears.
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp;
                if (w_wrap) begin
                    r_disp_val <= value;
                    r_disp_dp  <= dp;
                    r_pending  <= 1'b0;
                end else begin
                    r_pending  <= 1'b1;
                end
            end else if (w_wrap && r_pending) begin
                r_disp_val <= r_shadow_val;
                r_disp_dp  <= r_shadow_dp;
                r_pending  <= 1'b0;
            end

            // Two stages so the pulse lines up with digit 0's first an cycle.
            r_wrap_d     <= w_wrap;
            r_frame_done <= r_wrap_d;

            r_an  <= c_AN_ONE << r_idx;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = r_seg;
    assign seg_dp     = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_scan
// Description : Self-checking bench for seven_segment_scan (DIGITS=4,
//               REFRESH_DIV=4) against a frame-arithmetic reference model.
// Revision    : 1.0
// ============================================================================
module tb_seven_segment_scan;

    localparam int D = 4;
    localparam int R = 4;
    localparam int F = D * R;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic        error = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp    = '0;

    logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_dp;
    logic [3:0] an;
    logic       frame_done;
    logic [6:0] seg_out;

    seven_segment_scan #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .error      (error),
        .seg_a      (seg_a),
        .seg_b      (seg_b),
        .seg_c      (seg_c),
        .seg_d      (seg_d),
        .seg_e      (seg_e),
        .seg_f      (seg_f),
        .seg_g      (seg_g),
        .seg_dp     (seg_dp),
        .an         (an),
        .frame_done (frame_done)
    );

    assign seg_out = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] nib;
        logic [6:0] seg;
    } dec_vec_t;

    dec_vec_t dec_tab [16];

    int vectors = 0;
    int fails   = 0;

    // Reference model: n = rising edges since reset release.
    int          n = 0;
    logic [15:0] m_disp_v   = '0;
    logic [3:0]  m_disp_dp  = '0;
    logic [15:0] m_latest_v = '0;
    logic [3:0]  m_latest_dp = '0;
    logic [3:0]  e_an  = '0;
    logic [6:0]  e_seg = '0;
    logic        e_dp  = 1'b0;
    logic        e_fd  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", name, act, exp_v, n, $time);
        end
    endtask

    task automatic model_edge();
        int d;
        if (!rst_n) begin
            n = 0;
            m_disp_v = '0; m_disp_dp = '0;
            m_latest_v = '0; m_latest_dp = '0;
            e_an = '0; e_seg = '0; e_dp = 1'b0; e_fd = 1'b0;
        end else begin
            n++;
            d     = ((n - 1) / R) % D;
            e_an  = 4'b0001 << d;
            e_fd  = (n > 1) && (((n - 1) % F) == 0);
            e_seg = dec_tab[m_disp_v[d*4 +: 4]].seg;
            e_dp  = m_disp_dp[d];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            if (d > 0 && (m_disp_v >> (4 * d)) == 16'h0) begin
                e_seg = 7'b0000000;
                e_dp  = 1'b0;
            end
`endif
            if (error) begin
                e_seg = 7'b1001111;
                e_dp  = 1'b0;
            end
            if (load) begin
                m_latest_v  = value;
                m_latest_dp = dp;
            end
            if ((n % F) == 0) begin
                m_disp_v  = m_latest_v;
                m_disp_dp = m_latest_dp;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("an", {28'h0, an}, {28'h0, e_an});
        check("seg", {25'h0, seg_out}, {25'h0, e_seg});
        check("seg_dp", {31'h0, seg_dp}, {31'h0, e_dp});
        check("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p);
        value = v;
        dp    = p;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * F && !ok; i++) begin
            step();
            if (frame_done === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            vectors++;
            fails++;
            $display("FAIL %s: frame_done got 0 expected 1 within %0d cycles", name, 3 * F);
        end
    endtask

    task automatic align_to(input int phase);
        for (int i = 0; i < F && (n % F) != phase; i++) step();
    endtask

    initial begin
        dec_tab[0]  = '{4'h0, 7'b1111110};
        dec_tab[1]  = '{4'h1, 7'b0110000};
        dec_tab[2]  = '{4'h2, 7'b1101101};
        dec_tab[3]  = '{4'h3, 7'b1111001};
        dec_tab[4]  = '{4'h4, 7'b0110011};
        dec_tab[5]  = '{4'h5, 7'b1011011};
        dec_tab[6]  = '{4'h6, 7'b1011111};
        dec_tab[7]  = '{4'h7, 7'b1110000};
        dec_tab[8]  = '{4'h8, 7'b1111111};
        dec_tab[9]  = '{4'h9, 7'b1111011};
        dec_tab[10] = '{4'hA, 7'b1110111};
        dec_tab[11] = '{4'hB, 7'b0011111};
        dec_tab[12] = '{4'hC, 7'b1001110};
        dec_tab[13] = '{4'hD, 7'b0111101};
        dec_tab[14] = '{4'hE, 7'b1001111};
        dec_tab[15] = '{4'hF, 7'b1000111};

        // Reset release
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        step();
        check("reset_first_an", {28'h0, an}, 32'h1);
        check("reset_first_seg", {25'h0, seg_out}, 32'h7E);
        run(4);
        check("reset_an_after_4", {28'h0, an}, 32'h2);

        // Decode table: each nibble replicated, observed on digit 0
        for (int i = 0; i < 16; i++) begin
            do_load({4{dec_tab[i].nib}}, 4'b0000);
            wait_frame("decode_wait");
            check("decode_tab_seg", {25'h0, seg_out}, {25'h0, dec_tab[i].seg});
            check("decode_tab_an", {28'h0, an}, 32'h1);
        end

        // Load mid-frame, frame boundary update
        align_to(5);
        do_load(16'h1A3F, 4'b0000);
        run(2 * F + 4);

        // Back-to-back loads, last wins
        align_to(3);
        do_load(16'h1234, 4'b0000);
        do_load(16'h5678, 4'b0000);
        run(2 * F);

        // Load on the wrapping tick bypasses into display
        align_to(F - 1);
        do_load(16'hBEEF, 4'b0000);
        step();
        check("wrap_load_seg", {25'h0, seg_out}, 32'h47);
        check("wrap_load_an", {28'h0, an}, 32'h1);
        run(2 * F);

        // Error override and recovery with dp[2]
        do_load(16'h89AB, 4'b0100);
        run(2 * F);
        error = 1'b1;
        run(10);
        error = 1'b0;
        step();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < F + 2 && !seen; i++) begin
                step();
                if (an === 4'b0100) begin
                    seen = 1'b1;
                    check("dp2_restored", {31'h0, seg_dp}, 32'h1);
                end
            end
            if (!seen) begin
                vectors++;
                fails++;
                $display("FAIL dp2_wait: an got %0h expected 4 within %0d cycles", an, F + 2);
            end
        end

        // Leading zeros (blanked only when the macro is defined)
        do_load(16'h0040, 4'b0000);
        run(2 * F + 2);
        do_load(16'h0000, 4'b1111);
        run(2 * F + 2);

        // Reset mid-frame discards a pending load
        align_to(6);
        do_load(16'hC0DE, 4'b1010);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(2 * F + 2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            dp    = 4'($urandom);
            error = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 249) != 0);
            step();
        end
        load  = 1'b0;
        error = 1'b0;
        rst_n = 1'b1;
        run(F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
